// File: rtl/multiport_mem.sv
// Multi-port word memory: a round-robin arbiter feeding one transaction engine with a fixed
// LATENCY-cycle response. Define MULTIPORT_MEM_BOUNDS_CHECK_EN to flag out-of-range accesses.
module multiport_mem #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FETCH_WIDTH = 64,
  parameter int unsigned DEPTH       = 65536,
  parameter int unsigned LATENCY     = 2,
  localparam int unsigned SizeW      = $clog2(FETCH_WIDTH / 8)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             rd_en_i,
  input  logic [NUM_PORTS-1:0]             wr_en_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS*SizeW-1:0]       wr_size_i,
  input  logic [NUM_PORTS*FETCH_WIDTH-1:0] wr_data_i,
  output logic [NUM_PORTS-1:0]             busy_o,
  output logic [NUM_PORTS-1:0]             rdy_o,
  output logic [NUM_PORTS*FETCH_WIDTH-1:0] rd_data_o,
  output logic [NUM_PORTS-1:0]             err_o
);

  localparam int unsigned NumBytes = FETCH_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned PortW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW     = 4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PortW-1:0]       last_q, last_d;
  logic [PortW-1:0]       owner_q, owner_d;
  logic [FETCH_WIDTH-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [FETCH_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0]  addr_arr  [NUM_PORTS];
  logic [SizeW-1:0]       size_arr  [NUM_PORTS];
  logic [FETCH_WIDTH-1:0] wdata_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = addr_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign size_arr[i]  = wr_size_i[i*SizeW +: SizeW];
    assign wdata_arr[i] = wr_data_i[i*FETCH_WIDTH +: FETCH_WIDTH];
  end

  logic [NUM_PORTS-1:0] req;
  logic                 gnt_valid;
  logic [PortW-1:0]     gnt_idx;
  logic [PortW-1:0]     cand;

  assign req = rd_en_i | wr_en_i;

  // Search starts at the port after the last grant; no grant while reset is held.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (state_q == StIdle && !rst) begin
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
        cand = PortW'((32'(last_q) + k) % NUM_PORTS);
        if (!gnt_valid && req[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  logic                   sel_wr;
  logic [DATA_WIDTH-1:0]  sel_addr;
  logic [SizeW-1:0]       sel_size;
  logic [FETCH_WIDTH-1:0] sel_wdata;
  logic [IdxW-1:0]        idx;
  logic [OffW-1:0]        off;
  logic [DATA_WIDTH-1:0]  addr_hi;
  logic                   oob;
  logic [FETCH_WIDTH-1:0] wword;
  logic [NumBytes-1:0]    be;

  assign sel_wr    = wr_en_i[gnt_idx];
  assign sel_addr  = addr_arr[gnt_idx];
  assign sel_size  = size_arr[gnt_idx];
  assign sel_wdata = wdata_arr[gnt_idx];
  assign idx       = sel_addr[OffW +: IdxW];
  assign off       = sel_addr[OffW-1:0];
  assign addr_hi   = sel_addr >> (OffW + IdxW);
  assign wword     = sel_wdata << {off, 3'b000};

`ifdef MULTIPORT_MEM_BOUNDS_CHECK_EN
  assign oob = |addr_hi;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |addr_hi;
  assign oob            = 1'b0;
`endif

  // Bytes past the end of the word simply get no enable.
  always_comb begin
    be = '0;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      be[b] = (b >= 32'(off)) && ((b - 32'(off)) < (32'd1 << sel_size));
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_valid && sel_wr && !oob) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          rdata_d = (sel_wr || oob) ? '0 : mem_q[idx];
          err_d   = oob;
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= PortW'(NUM_PORTS - 1);
      owner_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy_o    = '0;
    rdy_o     = '0;
    rd_data_o = '0;
    err_o     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      busy_o[i] = (req[i] && !(gnt_valid && gnt_idx == PortW'(i))) ||
                  (state_q != StIdle && owner_q == PortW'(i));
      if (state_q == StResp && owner_q == PortW'(i)) begin
        rdy_o[i]                                = 1'b1;
        rd_data_o[i*FETCH_WIDTH +: FETCH_WIDTH] = rdata_q;
        err_o[i]                                = err_q;
      end
    end
  end

endmodule

// File: tb/tb_multiport_mem.sv
// Bench for multiport_mem: random and directed transactions on a 2-port LATENCY=2 instance
// checked against a byte-level model, plus LATENCY=1 and LATENCY=4 instances.
module tb_multiport_mem;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Main instance
  logic         rst;
  logic [1:0]   rd_en, wr_en, busy, rdy, err;
  logic [127:0] addr, wdata, rdata;
  logic [5:0]   wsize;

  multiport_mem #(.NUM_PORTS(2), .DATA_WIDTH(64), .FETCH_WIDTH(64), .DEPTH(DEPTH),
                  .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .rd_en_i(rd_en), .wr_en_i(wr_en), .addr_i(addr),
    .wr_size_i(wsize), .wr_data_i(wdata), .busy_o(busy), .rdy_o(rdy),
    .rd_data_o(rdata), .err_o(err)
  );

  // Single-port LATENCY=1 instance
  logic        rst1;
  logic [0:0]  rd1, wr1, busy1, rdy1, err1;
  logic [63:0] addr1, wdata1, rdata1;
  logic [2:0]  size1;

  multiport_mem #(.NUM_PORTS(1), .DATA_WIDTH(64), .FETCH_WIDTH(64), .DEPTH(16),
                  .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst1), .rd_en_i(rd1), .wr_en_i(wr1), .addr_i(addr1),
    .wr_size_i(size1), .wr_data_i(wdata1), .busy_o(busy1), .rdy_o(rdy1),
    .rd_data_o(rdata1), .err_o(err1)
  );

  // Two-port LATENCY=4 instance
  logic         rst4;
  logic [1:0]   rd4, wr4, busy4, rdy4, err4;
  logic [127:0] addr4, wdata4, rdata4;
  logic [5:0]   size4;

  multiport_mem #(.NUM_PORTS(2), .DATA_WIDTH(64), .FETCH_WIDTH(64), .DEPTH(16),
                  .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst4), .rd_en_i(rd4), .wr_en_i(wr4), .addr_i(addr4),
    .wr_size_i(size4), .wr_data_i(wdata4), .busy_o(busy4), .rdy_o(rdy4),
    .rd_data_o(rdata4), .err_o(err4)
  );

  // Reference model: flat byte array plus last-granted port
  logic [7:0]  mm [DEPTH*8];
  int          last_m;
  logic        op_rd [2];
  logic        op_wr [2];
  logic [63:0] op_addr [2];
  logic [63:0] op_data [2];
  logic [2:0]  op_size [2];
  logic [63:0] last_rd [2];
  logic        last_err [2];
  logic [63:0] pre1 [3];
  int          batch_no = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mword(input int w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = mm[w*8 + b];
    return r;
  endfunction

  task automatic model_access(input int p, output logic [63:0] d, output logic e);
    longint unsigned widx;
    int w, off;
    widx = op_addr[p] >> 3;
    d = '0;
    e = 1'b0;
`ifdef MULTIPORT_MEM_BOUNDS_CHECK_EN
    if (widx >= longint'(DEPTH)) begin
      e = 1'b1;
      return;
    end
`endif
    w   = int'(widx % DEPTH);
    off = int'(op_addr[p] % 8);
    if (op_wr[p]) begin
      for (int b = 0; b < (1 << op_size[p]); b++) begin
        if (off + b < 8) mm[w*8 + off + b] = op_data[p][8*b +: 8];
      end
    end else begin
      d = mword(w);
    end
  endtask

  // All ports in mask raise their request together in an idle cycle and hold it until
  // accepted. Round-robin order puts transaction k's acceptance at k*(LAT+1).
  task automatic run_batch(input logic [1:0] mask);
    int          ord [$];
    int          acc [2];
    logic [63:0] ed [2];
    logic        ee [2];
    logic        act, exp_rdy, exp_busy;
    int          total;
    string       t;
    batch_no++;
    for (int k = 1; k <= 2; k++) begin
      int p;
      p = (last_m + k) % 2;
      if (mask[p]) ord.push_back(p);
    end
    foreach (ord[k]) begin
      acc[ord[k]] = k * (LAT + 1);
      model_access(ord[k], ed[ord[k]], ee[ord[k]]);
    end
    total = ord.size() * (LAT + 1);
    for (int n = 0; n < total; n++) begin
      for (int p = 0; p < 2; p++) begin
        act                = mask[p] && n <= acc[p];
        rd_en[p]           = act && op_rd[p];
        wr_en[p]           = act && op_wr[p];
        addr[64*p +: 64]   = op_addr[p];
        wdata[64*p +: 64]  = op_data[p];
        wsize[3*p +: 3]    = op_size[p];
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        act      = mask[p] && n <= acc[p];
        exp_busy = (act && n != acc[p]) || (mask[p] && n > acc[p] && n <= acc[p] + LAT);
        exp_rdy  = mask[p] && n == acc[p] + LAT;
        t = $sformatf("b%0d n%0d p%0d", batch_no, n, p);
        chk({t, " busy"}, 64'(busy[p]), 64'(exp_busy));
        chk({t, " rdy"}, 64'(rdy[p]), 64'(exp_rdy));
        chk({t, " data"}, rdata[64*p +: 64], exp_rdy ? ed[p] : 64'h0);
        chk({t, " err"}, 64'(err[p]), exp_rdy ? 64'(ee[p]) : 64'h0);
        if (exp_rdy) begin
          last_rd[p]  = rdata[64*p +: 64];
          last_err[p] = err[p];
        end
      end
      @(posedge clk);
      #1;
    end
    rd_en = '0;
    wr_en = '0;
    last_m = ord[ord.size()-1];
  endtask

  task automatic set_op(input int p, input logic rd, input logic wr, input logic [63:0] a,
                        input logic [2:0] sz, input logic [63:0] d);
    op_rd[p] = rd; op_wr[p] = wr; op_addr[p] = a; op_size[p] = sz; op_data[p] = d;
  endtask

  task automatic rand_op(input int p);
    int r;
    r = $urandom_range(0, 3);
    op_rd[p] = (r != 2);
    op_wr[p] = (r >= 2);
    r = $urandom_range(0, 7);
    if (r == 0)      op_addr[p] = 64'(DEPTH*8) + 64'($urandom_range(0, 4095));
    else if (r == 1) op_addr[p] = {$urandom, $urandom};
    else if (r < 5)  op_addr[p] = 64'($urandom_range(0, 31));
    else             op_addr[p] = 64'($urandom_range(0, DEPTH*8 - 1));
    op_size[p] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7))
                                             : 3'($urandom_range(0, 3));
    op_data[p] = {$urandom, $urandom};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    logic [1:0]  m;
    rst = 1'b1; rst1 = 1'b1; rst4 = 1'b1;
    rd_en = '0; wr_en = '0; addr = '0; wdata = '0; wsize = '0;
    rd1 = '0; wr1 = '0; addr1 = '0; wdata1 = '0; size1 = '0;
    rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0; size4 = '0;
    for (int w = 0; w < DEPTH; w++) begin
      v = {$urandom, $urandom};
      u_dut.mem_q[w] <= v;
      for (int b = 0; b < 8; b++) mm[w*8 + b] = v[8*b +: 8];
    end
    for (int k = 0; k < 3; k++) begin
      pre1[k] = {$urandom, $urandom};
      u_l1.mem_q[k] <= pre1[k];
    end
    u_l4.mem_q[3] <= 64'h0;
    last_m = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst rdy", 64'(rdy), 64'h0);
    chk("rst data", rdata[63:0] | rdata[127:64], 64'h0);
    chk("rst err", 64'(err), 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    rst = 1'b0;

    // Full-word write then read back
    set_op(0, 1'b0, 1'b1, 64'h40, 3'd3, 64'h1122334455667788);
    run_batch(2'b01);
    set_op(0, 1'b1, 1'b0, 64'h40, 3'd0, 64'h0);
    run_batch(2'b01);
    chk("s035 readback", last_rd[0], 64'h1122334455667788);

    // Simultaneous reads after reset: port 0 first
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_m = 1;
    set_op(0, 1'b1, 1'b0, 64'h10, 3'd0, 64'h0);
    set_op(1, 1'b1, 1'b0, 64'h18, 3'd0, 64'h0);
    run_batch(2'b11);

    // Partial writes, including one that runs past the word boundary
    u_dut.mem_q[8] <= 64'h0;
    for (int b = 0; b < 8; b++) mm[64 + b] = 8'h0;
    set_op(0, 1'b0, 1'b1, 64'h43, 3'd0, 64'hAB);
    run_batch(2'b01);
    set_op(0, 1'b1, 1'b0, 64'h40, 3'd0, 64'h0);
    run_batch(2'b01);
    chk("s037 byte", last_rd[0], 64'h00000000AB000000);
    set_op(1, 1'b1, 1'b1, 64'h46, 3'd2, 64'hDDCCBBAA);
    run_batch(2'b10);
    set_op(1, 1'b1, 1'b0, 64'h40, 3'd0, 64'h0);
    run_batch(2'b10);
    chk("s037 tail", last_rd[1], 64'hBBAA0000AB000000);

    // Address just past the array
    set_op(0, 1'b1, 1'b0, 64'(DEPTH*8), 3'd0, 64'h0);
    run_batch(2'b01);
`ifdef MULTIPORT_MEM_BOUNDS_CHECK_EN
    chk("s040 data", last_rd[0], 64'h0);
    chk("s040 err", 64'(last_err[0]), 64'h1);
`else
    chk("s040 wrap", last_rd[0], mword(0));
    chk("s040 err", 64'(last_err[0]), 64'h0);
`endif

    for (int i = 0; i < 60; i++) begin
      m = 2'($urandom_range(1, 3));
      rand_op(0);
      rand_op(1);
      run_batch(m);
    end

    // LATENCY=1: back-to-back reads respond every other cycle
    rst1 = 1'b0;
    rd1  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr1 = 64'(k * 8);
      #1;
      chk($sformatf("l1 acc%0d busy", k), 64'(busy1), 64'h0);
      chk($sformatf("l1 acc%0d rdy", k), 64'(rdy1), 64'h0);
      @(posedge clk);
      #1;
      chk($sformatf("l1 rsp%0d rdy", k), 64'(rdy1), 64'h1);
      chk($sformatf("l1 rsp%0d busy", k), 64'(busy1), 64'h1);
      chk($sformatf("l1 rsp%0d data", k), rdata1, pre1[k]);
      @(posedge clk);
      #1;
    end
    rd1 = '0;

    // LATENCY=4: reset one cycle after an accepted write aborts the response
    rst4 = 1'b0;
    @(posedge clk);
    #1;
    wr4[0] = 1'b1;
    addr4[63:0] = 64'h18;
    size4[2:0] = 3'd3;
    wdata4[63:0] = 64'hCAFEF00D12345678;
    #1;
    chk("l4 accept busy", 64'(busy4), 64'h0);
    @(posedge clk);
    #1;
    wr4 = '0;
    rst4 = 1'b1;
    #1;
    chk("l4 rst rdy", 64'(rdy4), 64'h0);
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      #1;
      chk($sformatf("l4 quiet%0d", n), 64'(rdy4), 64'h0);
      @(posedge clk);
      #1;
    end
    rd4 = 2'b11;
    addr4 = {64'h0, 64'h18};
    #1;
    chk("l4 prio busy", 64'(busy4), 64'h2);
    @(posedge clk);
    #1;
    rd4[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("l4 rsp rdy", 64'(rdy4), 64'h1);
    chk("l4 retained", rdata4[63:0], 64'hCAFEF00D12345678);
    rd4 = '0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multiport_mem.md
MULTIPORT_MEM -- requirements
Module: multiport_mem

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester ports; legal range 1..8.
REQ-002 Parameter DATA_WIDTH, default 64: byte-address width.
REQ-003 Parameter FETCH_WIDTH, default 64: word width in bits; legal values 32 and 64.
REQ-004 Parameter DEPTH, default 65536: memory size in words; SHALL be a power of 2.
REQ-005 Parameter LATENCY, default 2: cycles from acceptance to response; legal range 1..15.
REQ-006 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port rd_en_i, input, NUM_PORTS: per-port read request.
REQ-009 Port wr_en_i, input, NUM_PORTS: per-port write request.
REQ-010 Port addr_i, input, NUM_PORTS*DATA_WIDTH: per-port byte address.
REQ-011 Port wr_size_i, input, NUM_PORTS*$clog2(FETCH_WIDTH/8): per-port write size; the write is 2^wr_size bytes.
REQ-012 Port wr_data_i, input, NUM_PORTS*FETCH_WIDTH: per-port write data, right-aligned.
REQ-013 Port busy_o, output, NUM_PORTS: the port's request is not accepted this cycle, or the port has a transaction outstanding.
REQ-014 Port rdy_o, output, NUM_PORTS: one-cycle response pulse.
REQ-015 Port rd_data_o, output, NUM_PORTS*FETCH_WIDTH: read data; valid only while the port's rdy_o is high.
REQ-016 Port err_o, output, NUM_PORTS: out-of-range flag; valid only while the port's rdy_o is high.

Function
REQ-017 The block SHALL run a single transaction engine with states IDLE, WAIT and RESP; at most one transaction is outstanding at any time.
REQ-018 In IDLE, a port is requesting when its rd_en_i or wr_en_i is high; the block SHALL grant exactly one requesting port using round-robin arbitration.
- The port after the last-granted port has highest priority.
REQ-019 A granted request is accepted on that clock edge.
- The engine moves to WAIT, loaded with a counter of LATENCY-1.
- With LATENCY=1, the engine moves directly to RESP.
REQ-020 In WAIT, the counter SHALL decrement each cycle; the engine moves to RESP when the counter reaches 0.
REQ-021 RESP SHALL last exactly one cycle.
- rdy_o of the owning port is high.
- The engine returns to IDLE.
- A new request can be accepted in the following cycle, not in the RESP cycle itself.
REQ-022 Response latency: rdy_o SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-023 busy_o[i] SHALL be combinational and high when either condition holds:
- port i requests and is not granted this cycle;
- port i owns the transaction in WAIT or RESP.
REQ-024 Requesters SHALL hold their request until busy_o is low; a request dropped while busy is lost without side effects.
REQ-025 If rd_en_i and wr_en_i are both high on a port, the request SHALL be treated as a write.
REQ-026 Word index SHALL be addr >> log2(FETCH_WIDTH/8), taken modulo DEPTH; the byte offset is the low address bits.
REQ-027 A write SHALL update the array on the acceptance edge.
- Bytes offset .. offset+2^wr_size-1 are written.
- Bytes that fall past the word boundary are dropped.
- For a write, rdy_o pulses with rd_data_o = 0.
REQ-028 A read SHALL capture the whole addressed word on the acceptance edge, so a read accepted after a write returns the written data.
REQ-029 rd_data_o and err_o SHALL be 0 for every port whose rdy_o is low.

Reset
REQ-030 While rst is high, the block SHALL hold the following:
- state IDLE and counter 0;
- rdy_o=0, rd_data_o=0, err_o=0;
- round-robin priority on port 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no response; an already-performed write is retained.
REQ-032 Reset SHALL NOT initialise memory contents; preloading is done by the bench through hierarchical access to the array.

Configuration
REQ-033 Macro MULTIPORT_MEM_BOUNDS_CHECK_EN defined:
- Any access whose word index is >= DEPTH, computed on the full DATA_WIDTH address, SHALL write nothing, read 0, and raise err_o with rdy_o.
REQ-034 Macro MULTIPORT_MEM_BOUNDS_CHECK_EN undefined:
- Addresses SHALL wrap modulo DEPTH and err_o is tied to 0.

Verification
REQ-035 Scenario: NUM_PORTS=2, LATENCY=2; port 0 writes 0x1122334455667788 at 0x40 with size 3 -> busy_o[0] is low on the accept cycle, rdy_o[0] pulses 2 cycles later, and a following read of 0x40 returns 0x1122334455667788.
REQ-036 Scenario: both ports request reads on the same cycle after reset -> port 0 responds first, and port 1 is accepted on the cycle after port 0's RESP.
- busy_o[1] stays high throughout.
REQ-037 Scenario: byte write of 0xAB at 0x43 to a word holding 0 -> reading 0x40 returns 0x00000000AB000000.
- A 4-byte write at 0x46 changes only bytes 6-7.
REQ-038 Scenario: LATENCY=1, three back-to-back reads from port 0 -> rdy_o pulses every 2 cycles, each one cycle after its acceptance.
REQ-039 Scenario: reset asserted one cycle after acceptance with LATENCY=4 -> no rdy_o pulse, state IDLE, and port 0 priority.
REQ-040 Scenario: read of byte address DEPTH*8 -> with the macro, err_o=1 and rd_data_o=0; without it, the data at word 0 is returned.
